// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows one at a time, debounces a single
// pressed key and reports it once per physical press via key_data/key_valid.
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         row_idx, row_nxt;
    logic [3:0]         col_meta, col_s;
    logic [3:0]         lat_col, lat_col_nxt;
    logic [3:0]         data_nxt;
    logic               valid_nxt, held_nxt;
    logic               single_press;
    logic               accept, release_key;

    function automatic logic [1:0] col_code(input logic [3:0] c);
        logic [1:0] code;
        code = 2'd0;
        case (c)
            4'b1101: code = 2'd1;
            4'b1011: code = 2'd2;
            4'b0111: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= key_col;
            col_s    <= col_meta;
        end
    end

    assign tick = scan_en && (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (!scan_en || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    assign single_press = ($countones(~col_s) == 1);

    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        row_nxt     = row_idx;
        lat_col_nxt = lat_col;
        data_nxt    = key_data;
        valid_nxt   = 1'b0;
        held_nxt    = key_held;
        accept      = 1'b0;
        release_key = 1'b0;

        if (!scan_en) begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
            row_nxt   = 2'd0;
            held_nxt  = 1'b0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (single_press) begin
                        lat_col_nxt = col_s;
                        if (DEBOUNCE_TICKS <= 1) begin
                            accept = 1'b1;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        row_nxt = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == lat_col) begin
                        if (int'(cnt) + 1 >= DEBOUNCE_TICKS)
                            accept = 1'b1;
                        else
                            cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        state_nxt = SCAN;
                        row_nxt   = row_idx + 2'd1;
                    end
                end
                HELD: begin
                    // Only a full release matters here; extra keys are ignored.
                    if (col_s == 4'hF) begin
                        if (DEBOUNCE_TICKS <= 1) begin
                            release_key = 1'b1;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (col_s == 4'hF) begin
                        if (int'(cnt) + 1 >= DEBOUNCE_TICKS)
                            release_key = 1'b1;
                        else
                            cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        state_nxt = HELD;
                    end
                end
            endcase
        end

        if (accept) begin
            data_nxt  = {row_idx, col_code(col_s)};
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = HELD;
        end
        if (release_key) begin
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
            row_nxt   = row_idx + 2'd1;
            state_nxt = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            cnt       <= '0;
            row_idx   <= 2'd0;
            lat_col   <= 4'hF;
            key_data  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_row   <= 4'b1110;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            row_idx   <= row_nxt;
            lat_col   <= lat_col_nxt;
            key_data  <= data_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
            // Row drive follows the next row index so a re-enable shows row 0 at once.
            key_row   <= scan_en ? ~(4'b0001 << row_nxt) : 4'b1111;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a modelled key matrix driven by directed presses,
// with expected key codes queued and checked whenever key_valid pulses.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        scan_en = 1'b1;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys    = '0;

    int          checks  = 0;
    int          errors  = 0;
    logic [3:0]  exp_q[$];
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .key_col  (key_col),
        .key_row  (key_row),
        .key_data (key_data),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        key_col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_row[r] && keys[4*r + c])
                    key_col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every key_valid pulse consumes one queued expected code.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                check("valid_back_to_back", {3'b0, prev_valid}, 4'h0);
                check("held_with_valid", {3'b0, key_held}, 4'h1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid: got key_data %h expected no pulse at %0t",
                             key_data, $time);
                end else begin
                    check("key_data", key_data, exp_q.pop_front());
                end
            end
            prev_valid = key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        int n = 0;
        while (key_held !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {3'b0, key_held}, {3'b0, v});
    endtask

    task automatic wait_row(input logic [3:0] v, input int budget, input string name);
        int n = 0;
        while (key_row !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, key_row, v);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (key_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {3'b0, key_valid}, 4'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rot [4];
        rot[0] = 4'b1101;
        rot[1] = 4'b1011;
        rot[2] = 4'b0111;
        rot[3] = 4'b1110;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("reset_key_row", key_row, 4'b1110);
        check("reset_key_data", key_data, 4'd0);
        check("reset_key_valid", {3'b0, key_valid}, 4'h0);
        check("reset_key_held", {3'b0, key_held}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);

        // Clean press row2 col1 -> code 9.
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        cycles(40);
        check("press9_held", {3'b0, key_held}, 4'h1);
        check("press9_data", key_data, 4'd9);
        keys[9] = 1'b0;
        cycles(8);
        check("press9_held_in_release_debounce", {3'b0, key_held}, 4'h1);
        wait_held(1'b0, 30, "press9_released");
        check("press9_resume_row3", key_row, 4'b0111);

        // Bounce on row1 col0 lasting a single tick.
        wait_row(4'b1101, 40, "bounce_reach_row1");
        keys[4] = 1'b1;
        cycles(4);
        keys[4] = 1'b0;
        cycles(4);
        check("bounce_row_advance", key_row, 4'b1011);
        check("bounce_data_kept", key_data, 4'd9);
        check("bounce_not_held", {3'b0, key_held}, 4'h0);

        // Two keys on row0 at once: rows keep rotating.
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        wait_row(4'b0111, 40, "multi_reach_row3");
        wait_row(4'b1110, 40, "multi_reach_row0");
        for (int i = 0; i < 4; i++) begin
            cycles(4);
            check("multi_rotation", key_row, rot[i]);
        end
        keys[0] = 1'b0;
        keys[3] = 1'b0;
        check("multi_data_kept", key_data, 4'd9);

        // Long hold on row3 col3 with a one-tick release bounce.
        keys[15] = 1'b1;
        exp_q.push_back(4'd15);
        wait_held(1'b1, 60, "press15_held");
        cycles(8);
        keys[15] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("press15_held_bounce_up", {3'b0, key_held}, 4'h1);
        end
        keys[15] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("press15_held_bounce_down", {3'b0, key_held}, 4'h1);
        end
        keys[15] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("press15_held_final_release", {3'b0, key_held}, 4'h1);
        end
        wait_held(1'b0, 40, "press15_released");
        check("press15_data", key_data, 4'd15);

        // Enable gating while held on row1 col2 -> code 6.
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_held(1'b1, 60, "press6_held");
        @(negedge clk);
        scan_en = 1'b0;
        @(negedge clk);
        check("disable_key_row", key_row, 4'b1111);
        check("disable_key_held", {3'b0, key_held}, 4'h0);
        check("disable_data_kept", key_data, 4'd6);
        keys[6] = 1'b0;
        cycles(3);
        check("disable_row_stays", key_row, 4'b1111);
        scan_en = 1'b1;
        @(negedge clk);
        check("enable_key_row", key_row, 4'b1110);
        keys[10] = 1'b1;
        exp_q.push_back(4'd10);
        wait_held(1'b1, 60, "press10_held");
        keys[10] = 1'b0;
        wait_held(1'b0, 40, "press10_released");
        check("press10_data", key_data, 4'd10);

        // Reset asserted during a key_valid pulse on row1 col1 -> code 5.
        keys[5] = 1'b1;
        exp_q.push_back(4'd5);
        wait_valid(60, "press5_valid");
        #1 rst_n = 1'b0;
        #1;
        check("midreset_key_valid", {3'b0, key_valid}, 4'h0);
        check("midreset_key_data", key_data, 4'd0);
        check("midreset_key_row", key_row, 4'b1110);
        check("midreset_key_held", {3'b0, key_held}, 4'h0);
        keys[5] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5);

        check("queue_drained", 4'(exp_q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
